// File: rtl/mem_cache_stage.sv
// mem_cache_stage
// ---------------
// MEM pipeline stage built around a direct-mapped, write-back data cache
// with one 32-bit word per line. A hit or a non-memory entry finishes in one
// cycle. A miss stalls the front of the pipe, writes back a dirty victim if
// there is one, fills the line from main memory, then finishes the access in
// a DONE cycle exactly as if it had hit.
//
// Parameters
//   INDEX_BITS   log2 of the number of cache lines
//   MEM_TIMEOUT  cycles a memory request may wait for mem_ack before the
//                stage gives up and raises the sticky mem_error
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   mem_access, we_cache     entry is a load/store, 1 = store
//   is_word                  1 = word access, 0 = byte access
//   ALU_result, rt_data      effective address (or plain result), store data
//   rd_num_in, register_write_in, register_src_in   writeback controls from EX
//   stall                    freezes IF..EX and holds the EX/MEM inputs
//   mem_read_data, ALU_result_out, rd_num_out,
//   register_write_out, register_src_out            registered MEM/WB outputs
//   mem_req, mem_we, mem_addr, mem_wdata            main-memory request side
//   mem_rdata, mem_ack       main-memory read data and one-cycle completion
//   mem_error                sticky flag, set when a request times out
//
// Build option
//   MEM_CACHE_STATS_EN  when defined, adds saturating 32-bit outputs
//                       hit_count, miss_count and wb_count.

module mem_cache_stage #(
   parameter int INDEX_BITS  = 3,
   parameter int MEM_TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_access,
   input  logic        we_cache,
   input  logic        is_word,
   input  logic [31:0] ALU_result,
   input  logic [31:0] rt_data,
   input  logic [4:0]  rd_num_in,
   input  logic        register_write_in,
   input  logic [1:0]  register_src_in,
   output logic        stall,
   output logic [31:0] mem_read_data,
   output logic [31:0] ALU_result_out,
   output logic [4:0]  rd_num_out,
   output logic        register_write_out,
   output logic [1:0]  register_src_out,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ack,
   output logic        mem_error
`ifdef MEM_CACHE_STATS_EN
   ,
   output logic [31:0] hit_count,
   output logic [31:0] miss_count,
   output logic [31:0] wb_count
`endif
);

   localparam int LINES    = 1 << INDEX_BITS;
   localparam int TAG_BITS = 30 - INDEX_BITS;
   localparam int CNT_BITS = $clog2(MEM_TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, WRITEBACK, FILL, DONE} state_t;

   state_t state_q, state_d;

   logic [LINES-1:0]    line_valid;
   logic [LINES-1:0]    line_dirty;
   logic [TAG_BITS-1:0] line_tag  [LINES];
   logic [31:0]         line_data [LINES];

   logic [CNT_BITS-1:0] tmo_cnt;
   logic                timed_out_q;
   logic                mem_error_q;

   logic [INDEX_BITS-1:0] acc_index;
   logic [TAG_BITS-1:0]   acc_tag;
   logic [1:0]            acc_offset;
   logic [TAG_BITS-1:0]   cur_tag;
   logic [31:0]           cur_data;

   logic        hit;
   logic        victim_dirty;
   logic        miss_detect;
   logic        in_mem;
   logic        timeout;
   logic        complete;
   logic        access_ok;
   logic        store_hit;
   logic        fill_done;
   logic [7:0]  sel_byte;
   logic [31:0] load_value;
   logic [31:0] store_value;

   assign acc_offset = ALU_result[1:0];
   assign acc_index  = ALU_result[INDEX_BITS+1:2];
   assign acc_tag    = ALU_result[31:INDEX_BITS+2];
   assign cur_tag    = line_tag[acc_index];
   assign cur_data   = line_data[acc_index];

   assign hit          = line_valid[acc_index] && (cur_tag == acc_tag);
   assign victim_dirty = line_valid[acc_index] && line_dirty[acc_index];
   assign miss_detect  = (state_q == IDLE) && mem_access && !hit;
   assign in_mem       = (state_q == WRITEBACK) || (state_q == FILL);
   assign timeout      = in_mem && !mem_ack && (tmo_cnt == CNT_BITS'(MEM_TIMEOUT - 1));
   assign fill_done    = (state_q == FILL) && mem_ack;

   // "complete" is the cycle in which the MEM/WB registers take the entry.
   // After a timeout the DONE cycle still retires the instruction, but the
   // line is left alone and a load returns zero.
   assign complete  = ((state_q == IDLE) && !miss_detect) || (state_q == DONE);
   assign access_ok = complete && mem_access && !((state_q == DONE) && timed_out_q);
   assign store_hit = access_ok && we_cache;

   assign mem_error = mem_error_q;

   // Byte lane selection for loads and byte merge for stores; offset 0 is
   // the least significant byte.
   always_comb begin
      sel_byte    = cur_data[7:0];
      store_value = rt_data;
      if (!is_word) begin
         store_value = cur_data;
         case (acc_offset)
            2'd0: begin
               sel_byte          = cur_data[7:0];
               store_value[7:0]  = rt_data[7:0];
            end
            2'd1: begin
               sel_byte          = cur_data[15:8];
               store_value[15:8] = rt_data[7:0];
            end
            2'd2: begin
               sel_byte           = cur_data[23:16];
               store_value[23:16] = rt_data[7:0];
            end
            default: begin
               sel_byte           = cur_data[31:24];
               store_value[31:24] = rt_data[7:0];
            end
         endcase
      end
      load_value = is_word ? cur_data : {{24{sel_byte[7]}}, sel_byte};
   end

   // FSM state register, plus the request timeout counter and its flags.
   // The counter restarts on every state change so that a writeback and the
   // following fill each get the full timeout budget.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         tmo_cnt     <= '0;
         timed_out_q <= 1'b0;
         mem_error_q <= 1'b0;
      end else begin
         state_q <= state_d;
         if (in_mem && !mem_ack && !timeout) begin
            tmo_cnt <= tmo_cnt + 1'b1;
         end else begin
            tmo_cnt <= '0;
         end
         if (timeout) begin
            timed_out_q <= 1'b1;
            mem_error_q <= 1'b1;
         end else if (state_q == DONE) begin
            timed_out_q <= 1'b0;
         end
      end
   end

   // FSM next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (miss_detect) begin
               state_d = victim_dirty ? WRITEBACK : FILL;
            end
         end
         WRITEBACK: begin
            if (mem_ack) begin
               state_d = FILL;
            end else if (timeout) begin
               state_d = DONE;
            end
         end
         FILL: begin
            if (mem_ack || timeout) begin
               state_d = DONE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // FSM outputs. The request is a pure function of the state and the held
   // EX/MEM inputs, so it is stable until acknowledged and drops the moment
   // an asynchronous reset forces the state back to IDLE. The writeback
   // address is rebuilt from the victim's stored tag.
   always_comb begin
      stall     = !rst && (miss_detect || in_mem);
      mem_req   = in_mem;
      mem_we    = 1'b0;
      mem_addr  = 32'd0;
      mem_wdata = 32'd0;
      case (state_q)
         WRITEBACK: begin
            mem_we    = 1'b1;
            mem_addr  = {cur_tag, acc_index, 2'b00};
            mem_wdata = cur_data;
         end
         FILL: begin
            mem_addr = {ALU_result[31:2], 2'b00};
         end
         default: ;
      endcase
   end

   // Valid and dirty bits need a reset; a fill makes the line clean and a
   // store (hit or post-fill) marks it dirty.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         line_valid <= '0;
         line_dirty <= '0;
      end else begin
         if (fill_done) begin
            line_valid[acc_index] <= 1'b1;
            line_dirty[acc_index] <= 1'b0;
         end else if (store_hit) begin
            line_dirty[acc_index] <= 1'b1;
         end
      end
   end

   // Tag and data arrays carry no reset; they are only meaningful once the
   // matching valid bit is set.
   always_ff @(posedge clk) begin
      if (fill_done) begin
         line_tag[acc_index]  <= acc_tag;
         line_data[acc_index] <= mem_rdata;
      end else if (store_hit) begin
         line_data[acc_index] <= store_value;
      end
   end

   // MEM/WB pipeline register. While stalled a bubble is injected by
   // clearing register_write_out; everything else holds its value.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_read_data      <= 32'd0;
         ALU_result_out     <= 32'd0;
         rd_num_out         <= 5'd0;
         register_write_out <= 1'b0;
         register_src_out   <= 2'd0;
      end else if (complete) begin
         mem_read_data      <= (access_ok && !we_cache) ? load_value : 32'd0;
         ALU_result_out     <= ALU_result;
         rd_num_out         <= rd_num_in;
         register_write_out <= register_write_in;
         register_src_out   <= register_src_in;
      end else begin
         register_write_out <= 1'b0;
      end
   end

`ifdef MEM_CACHE_STATS_EN
   // Access statistics: one hit or miss per memory access (a miss is counted
   // in its detecting cycle only), one writeback per dirty eviction.
   // All counters stop at their maximum value instead of wrapping.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hit_count  <= 32'd0;
         miss_count <= 32'd0;
         wb_count   <= 32'd0;
      end else begin
         if ((state_q == IDLE) && mem_access && hit && (hit_count != '1)) begin
            hit_count <= hit_count + 32'd1;
         end
         if (miss_detect && (miss_count != '1)) begin
            miss_count <= miss_count + 32'd1;
         end
         if (miss_detect && victim_dirty && (wb_count != '1)) begin
            wb_count <= wb_count + 32'd1;
         end
      end
   end
`else
   // No statistics hardware in this build.
`endif

endmodule

// File: tb/tb_mem_cache_stage.sv
// tb_mem_cache_stage
// ------------------
// Self-checking bench for mem_cache_stage. The reference is architectural:
// a golden word memory holds what every load must return, a backing memory
// answers the DUT's requests, and a per-index residency table predicts hits,
// misses, dirty evictions and therefore the exact stall length and request
// sequence. Directed cases cover the cold miss, byte store/load, dirty
// eviction, timeout and reset-during-fill scenarios; a randomized phase
// follows.

module tb_mem_cache_stage;

   localparam int TIMEOUT = 255;

   logic        clk;
   logic        rst;
   logic        mem_access;
   logic        we_cache;
   logic        is_word;
   logic [31:0] ALU_result;
   logic [31:0] rt_data;
   logic [4:0]  rd_num_in;
   logic        register_write_in;
   logic [1:0]  register_src_in;
   logic        stall;
   logic [31:0] mem_read_data;
   logic [31:0] ALU_result_out;
   logic [4:0]  rd_num_out;
   logic        register_write_out;
   logic [1:0]  register_src_out;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_ack;
   logic        mem_error;
`ifdef MEM_CACHE_STATS_EN
   logic [31:0] hit_count;
   logic [31:0] miss_count;
   logic [31:0] wb_count;
`endif

   logic [31:0] backing [128];
   logic [31:0] golden  [128];
   bit          res_valid [8];
   bit          res_dirty [8];
   logic [26:0] res_tag   [8];
   bit          err_model;

   int checks   = 0;
   int failures = 0;

   mem_cache_stage #(
      .INDEX_BITS (3),
      .MEM_TIMEOUT(TIMEOUT)
   ) dut (
      .clk               (clk),
      .rst               (rst),
      .mem_access        (mem_access),
      .we_cache          (we_cache),
      .is_word           (is_word),
      .ALU_result        (ALU_result),
      .rt_data           (rt_data),
      .rd_num_in         (rd_num_in),
      .register_write_in (register_write_in),
      .register_src_in   (register_src_in),
      .stall             (stall),
      .mem_read_data     (mem_read_data),
      .ALU_result_out    (ALU_result_out),
      .rd_num_out        (rd_num_out),
      .register_write_out(register_write_out),
      .register_src_out  (register_src_out),
      .mem_req           (mem_req),
      .mem_we            (mem_we),
      .mem_addr          (mem_addr),
      .mem_wdata         (mem_wdata),
      .mem_rdata         (mem_rdata),
      .mem_ack           (mem_ack),
      .mem_error         (mem_error)
`ifdef MEM_CACHE_STATS_EN
      ,
      .hit_count         (hit_count),
      .miss_count        (miss_count),
      .wb_count          (wb_count)
`endif
   );

   // Free-running 100 MHz clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Safety net in case some wait is never satisfied.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: actual still running, required finished");
      $fatal(1, "[TB] watchdog expired");
   end

   // Single comparison point: counts and reports.
   task automatic checkOutput(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: actual 0x%08h required 0x%08h", tag, actual, expected);
      end
   endtask

   function automatic logic [31:0] loadByte(input logic [31:0] w, input logic [1:0] off);
      logic [31:0] shifted;
      shifted = w >> (8 * off);
      return {{24{shifted[7]}}, shifted[7:0]};
   endfunction

   function automatic logic [31:0] mergeByte(input logic [31:0] w, input logic [1:0] off,
                                             input logic [7:0] b);
      return (w & ~(32'hFF << (8 * off))) | ({24'd0, b} << (8 * off));
   endfunction

   // After a reset the cache is empty and any dirty data is gone, so the
   // architectural view falls back to whatever main memory holds.
   task automatic resetModel();
      for (int i = 0; i < 8; i++) begin
         res_valid[i] = 1'b0;
         res_dirty[i] = 1'b0;
         res_tag[i]   = '0;
      end
      for (int i = 0; i < 128; i++) golden[i] = backing[i];
      err_model = 1'b0;
   endtask

   task automatic checkResetOutputs(input string pfx);
      checkOutput({pfx, "_stall"},    32'(stall), 32'd0);
      checkOutput({pfx, "_mem_req"},  32'(mem_req), 32'd0);
      checkOutput({pfx, "_mem_we"},   32'(mem_we), 32'd0);
      checkOutput({pfx, "_mem_addr"}, mem_addr, 32'd0);
      checkOutput({pfx, "_mem_wdata"}, mem_wdata, 32'd0);
      checkOutput({pfx, "_rdata"},    mem_read_data, 32'd0);
      checkOutput({pfx, "_alu_out"},  ALU_result_out, 32'd0);
      checkOutput({pfx, "_rd_out"},   32'(rd_num_out), 32'd0);
      checkOutput({pfx, "_rw_out"},   32'(register_write_out), 32'd0);
      checkOutput({pfx, "_src_out"},  32'(register_src_out), 32'd0);
      checkOutput({pfx, "_mem_err"},  32'(mem_error), 32'd0);
   endtask

   task automatic pulseReset();
      rst        = 1'b1;
      mem_access = 1'b0;
      mem_ack    = 1'b0;
      @(posedge clk);
      #1;
      checkResetOutputs("reset");
      rst = 1'b0;
      resetModel();
   endtask

   // Presents one EX/MEM entry, services memory traffic with the given ack
   // delay, and checks the retired MEM/WB outputs. Called #1 after a rising
   // edge; returns #1 after the edge that retired the entry.
   task automatic applyStimulus(input bit acc, input bit we, input bit word,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input int ack_delay, input bit rw,
                                output logic [31:0] rdata_obs, output int stall_obs);
      int          idx, w, nreq, k, req_cycles, cyc, exp_stall;
      bit          is_hit, need_wb, tmo;
      logic [31:0] req_addr [2];
      logic        req_we   [2];
      logic [31:0] req_data [2];
      logic [31:0] exp_rdata;
      logic [31:0] wb_word;
      logic [4:0]  rd;
      logic [1:0]  src;

      idx     = int'(addr[4:2]);
      w       = int'(addr[8:2]);
      is_hit  = !acc || (res_valid[idx] && (res_tag[idx] == addr[31:5]));
      need_wb = !is_hit && res_valid[idx] && res_dirty[idx];
      tmo     = !is_hit && (ack_delay >= TIMEOUT);
      nreq    = 0;
      for (int i = 0; i < 2; i++) begin
         req_addr[i] = 32'd0;
         req_we[i]   = 1'b0;
         req_data[i] = 32'd0;
      end
      if (!is_hit) begin
         if (need_wb) begin
            wb_word     = {res_tag[idx], addr[4:2], 2'b00};
            req_addr[0] = wb_word;
            req_we[0]   = 1'b1;
            req_data[0] = golden[wb_word[8:2]];
            nreq        = 1;
         end
         if (!(tmo && need_wb)) begin
            req_addr[nreq] = {addr[31:2], 2'b00};
            req_we[nreq]   = 1'b0;
            nreq++;
         end
      end
      exp_stall = is_hit ? 0 : 1 + nreq * (tmo ? TIMEOUT : ack_delay + 1);
      exp_rdata = 32'd0;
      if (acc && !we && !tmo) exp_rdata = word ? golden[w] : loadByte(golden[w], addr[1:0]);

      rd  = 5'($urandom);
      src = 2'($urandom);
      mem_access        = acc;
      we_cache          = we;
      is_word           = word;
      ALU_result        = addr;
      rt_data           = wdata;
      rd_num_in         = rd;
      register_write_in = rw;
      register_src_in   = src;
      #1;

      stall_obs  = 0;
      k          = 0;
      req_cycles = 0;
      cyc        = 0;
      while (stall === 1'b1 && cyc < 2000) begin
         stall_obs++;
         if (mem_req === 1'b1) begin
            if (k < nreq) begin
               checkOutput("mem_we", 32'(mem_we), 32'(req_we[k]));
               checkOutput("mem_addr", mem_addr, req_addr[k]);
               if (req_we[k]) checkOutput("mem_wdata", mem_wdata, req_data[k]);
            end else begin
               checkOutput("extra_req", 32'(mem_req), 32'd0);
            end
            req_cycles++;
            if (req_cycles > ack_delay) begin
               mem_ack = 1'b1;
               if (mem_we) backing[mem_addr[8:2]] = mem_wdata;
               else        mem_rdata = backing[mem_addr[8:2]];
               k++;
               req_cycles = 0;
            end
         end
         @(posedge clk);
         #1;
         mem_ack   = 1'b0;
         mem_rdata = $urandom;
         cyc++;
         checkOutput("bubble_rw", 32'(register_write_out), 32'd0);
      end
      if (cyc >= 2000) checkOutput("stall_bound", 32'(cyc), 32'd0);

      @(posedge clk);
      #1;
      rdata_obs = mem_read_data;
      checkOutput("stall_cycles", 32'(stall_obs), 32'(exp_stall));
      checkOutput("req_count", 32'(k), 32'(tmo ? 0 : nreq));
      checkOutput("rdata", mem_read_data, exp_rdata);
      checkOutput("alu_out", ALU_result_out, addr);
      checkOutput("rd_out", 32'(rd_num_out), 32'(rd));
      checkOutput("rw_out", 32'(register_write_out), 32'(rw));
      checkOutput("src_out", 32'(register_src_out), 32'(src));

      if (acc && !tmo) begin
         if (!is_hit) begin
            res_valid[idx] = 1'b1;
            res_tag[idx]   = addr[31:5];
            res_dirty[idx] = 1'b0;
         end
         if (we) begin
            golden[w]      = word ? wdata : mergeByte(golden[w], addr[1:0], wdata[7:0]);
            res_dirty[idx] = 1'b1;
         end
      end
      if (tmo) err_model = 1'b1;
      checkOutput("mem_error", 32'(mem_error), 32'(err_model));
   endtask

   initial begin
      logic [31:0] rdata;
      int          st;
      bit          acc, we, word;
      logic [31:0] addr;

      rst               = 1'b1;
      mem_access        = 1'b0;
      we_cache          = 1'b0;
      is_word           = 1'b0;
      ALU_result        = 32'd0;
      rt_data           = 32'd0;
      rd_num_in         = 5'd0;
      register_write_in = 1'b0;
      register_src_in   = 2'd0;
      mem_rdata         = 32'd0;
      mem_ack           = 1'b0;
      for (int i = 0; i < 128; i++) backing[i] = $urandom;
      backing[16] = 32'h1234_5678;

      pulseReset();

      // Cold word load at 0x40.
      applyStimulus(1, 0, 1, 32'h0000_0040, 32'd0, 1, 1, rdata, st);
      checkOutput("cold_load_data", rdata, 32'h1234_5678);
      checkOutput("cold_load_stall_min", 32'(st >= 2), 32'd1);
      checkOutput("cold_load_rw", 32'(register_write_out), 32'd1);

      // Byte store hits without stalling, then byte and word reloads.
      applyStimulus(1, 1, 0, 32'h0000_0041, 32'h0000_0080, 0, 1, rdata, st);
      checkOutput("byte_store_no_stall", 32'(st), 32'd0);
      applyStimulus(1, 0, 0, 32'h0000_0041, 32'd0, 0, 1, rdata, st);
      checkOutput("byte_load_sext", rdata, 32'hFFFF_FF80);
      applyStimulus(1, 0, 1, 32'h0000_0040, 32'd0, 0, 1, rdata, st);
      checkOutput("word_after_merge", rdata, 32'h1234_8078);

      // Conflicting load evicts the dirty line first.
      applyStimulus(1, 0, 1, 32'h0000_0060, 32'd0, 2, 1, rdata, st);
      checkOutput("evict_wb_data", backing[16], 32'h1234_8078);
      checkOutput("evict_stall", 32'(st), 32'd7);

      // Non-memory pass-through.
      applyStimulus(0, 0, 1, 32'hDEAD_BEEF, 32'd0, 0, 1, rdata, st);
      checkOutput("passthru_no_stall", 32'(st), 32'd0);

      // Randomized mix of loads, stores and pass-through entries.
      for (int n = 0; n < 150; n++) begin
         acc  = ($urandom_range(0, 3) != 0);
         we   = 1'($urandom);
         word = 1'($urandom);
         if (word) addr = {23'd0, 7'($urandom_range(0, 127)), 2'b00};
         else      addr = 32'($urandom_range(0, 511));
         applyStimulus(acc, we, word, addr, $urandom, $urandom_range(0, 3),
                       1'($urandom), rdata, st);
      end

      pulseReset();

      // Fill never acknowledged: timeout, zero data, error, line stays empty.
      applyStimulus(1, 0, 1, 32'h0000_001C, 32'd0, 100000, 1, rdata, st);
      checkOutput("timeout_data", rdata, 32'd0);
      checkOutput("timeout_error", 32'(mem_error), 32'd1);
      checkOutput("timeout_stall", 32'(st), 32'(TIMEOUT + 1));
      applyStimulus(0, 0, 1, 32'h0000_1234, 32'd0, 0, 1, rdata, st);
      checkOutput("timeout_back_idle", 32'(st), 32'd0);
      applyStimulus(1, 0, 1, 32'h0000_001C, 32'd0, 0, 1, rdata, st);
      checkOutput("timeout_line_invalid", 32'(st > 0), 32'd1);

      // Reset in the middle of a fill.
      mem_access = 1'b1;
      we_cache   = 1'b0;
      is_word    = 1'b1;
      ALU_result = 32'h0000_0040;
      #1;
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      checkOutput("rst_fill_req_before", 32'(mem_req), 32'd1);
      rst = 1'b1;
      #1;
      checkOutput("rst_fill_req_drop", 32'(mem_req), 32'd0);
      checkOutput("rst_fill_stall", 32'(stall), 32'd0);
      checkOutput("rst_fill_rw", 32'(register_write_out), 32'd0);
      checkOutput("rst_fill_error", 32'(mem_error), 32'd0);
      @(posedge clk);
      #1;
      mem_access = 1'b0;
      rst        = 1'b0;
      resetModel();
      applyStimulus(1, 0, 1, 32'h0000_0040, 32'd0, 1, 1, rdata, st);
      checkOutput("rst_fill_remiss", 32'(st > 0), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule

// File: doc/mem_cache_stage.md
MEM_CACHE_STAGE -- requirements
Module: mem_cache_stage

Interface
REQ-001 Parameter INDEX_BITS, default 3: cache has 2**INDEX_BITS direct-mapped one-word lines.
REQ-002 Parameter MEM_TIMEOUT, default 255: maximum mem_ack wait cycles before error.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 mem_access  input  1  EX/MEM entry is a load or store.
REQ-006 we_cache  input  1  1=store, 0=load (valid with mem_access).
REQ-007 is_word  input  1  1=word, 0=byte access.
REQ-008 ALU_result  input  32  effective address / non-memory result.
REQ-009 rt_data  input  32  store data.
REQ-010 rd_num_in, register_write_in, register_src_in  input  5/1/2  writeback controls from EX.
REQ-011 stall  output  1  freeze IF..EX and hold EX/MEM inputs.
REQ-012 mem_read_data, ALU_result_out  output  32/32  registered MEM/WB data.
REQ-013 rd_num_out, register_write_out, register_src_out  output  5/1/2  registered MEM/WB controls.
REQ-014 mem_req, mem_we  output  1/1  main-memory request, write strobe.
REQ-015 mem_addr, mem_wdata  output  32/32  word-aligned address, write data.
REQ-016 mem_rdata, mem_ack  input  32/1  read data, one-cycle completion pulse.
REQ-017 mem_error  output  1  sticky, set on timeout.

Function
REQ-018 Address split: offset=[1:0], index=[INDEX_BITS+1:2], tag=[31:INDEX_BITS+2]; each line holds valid, dirty, tag, 32-bit data.
REQ-019 FSM states IDLE, WRITEBACK, FILL, DONE; reset to IDLE.
REQ-020 IDLE, no mem_access or hit: MEM/WB registers load next edge, stall=0, latency 1 cycle.
REQ-021 Load hit: word returned; byte load returns byte at offset (0=bits 7:0), sign-extended to 32 bits.
REQ-022 Store hit: word replaces line, byte merges at offset; dirty set.
REQ-023 Miss with victim valid and dirty: stall=1 combinationally that cycle, go WRITEBACK; else go FILL.
REQ-024 WRITEBACK: mem_req=1, mem_we=1, mem_addr={victim tag,index,2'b00}, mem_wdata=line data; on mem_ack go FILL.
REQ-025 FILL: mem_req=1, mem_we=0, mem_addr={addr[31:2],2'b00}; on mem_ack write line, valid=1, dirty=0, go DONE.
REQ-026 DONE: access completes as a hit (REQ-021/022), stall=0, then IDLE.
REQ-027 stall=1 in every cycle of WRITEBACK and FILL and in the detecting miss cycle.
REQ-028 mem_req, mem_addr, mem_we, mem_wdata held stable until mem_ack; mem_ack outside WRITEBACK/FILL ignored.
REQ-029 During stall, register_write_out=0 (bubble); other MEM/WB outputs hold.
REQ-030 Timeout: MEM_TIMEOUT cycles without mem_ack sets mem_error, line unchanged, FSM goes DONE treating rdata as 0.
REQ-031 Non-memory entries (mem_access=0) pass ALU_result, rd_num, controls through with 1-cycle latency; mem_read_data=0.

Reset
REQ-032 rst asserted: FSM=IDLE, all valid and dirty bits=0, all outputs 0, mem_error=0, timeout counter=0.
REQ-033 rst mid-WRITEBACK/FILL aborts immediately; mem_req drops same cycle; no line is updated.

Configuration
REQ-034 Macro MEM_CACHE_STATS_EN defined: add 32-bit outputs hit_count, miss_count, wb_count, saturating, reset 0, counting once per access/writeback.
REQ-035 Macro undefined: those ports and counters are absent; all other behaviour identical.

Verification
REQ-036 Load 0x0000_0040 cold -> stall 2 cycles min, mem_req read addr 0x40, mem_rdata=0x1234_5678 -> mem_read_data=0x1234_5678, register_write_out=1 after DONE.
REQ-037 Store byte 0x80 to 0x41 after REQ-036 -> no stall; later load byte 0x41 -> 0xFFFF_FF80; load word 0x40 -> 0x1234_8078.
REQ-038 Load 0x0000_0060 (same index, dirty victim) -> write 0x1234_8078 to 0x40 first, then read 0x60; stall until fill ack.
REQ-039 mem_ack withheld 255 cycles in FILL -> mem_error=1, mem_read_data=0, FSM IDLE, line invalid.
REQ-040 rst pulse during FILL -> mem_req=0 same cycle, later load 0x40 misses again.
